// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_arbiter
// Purpose  : Round-robin arbiter that shares the single write port of the SPI
//            TX FIFO between NUM_REQ producers. A grant lasts until the owner
//            flags its last word, reaches MAX_BURST words, or stalls (valid
//            low) for STALL_TIMEOUT cycles. FIFO_FULL backpressure never
//            counts as a stall.
// Ports    : clk_i        - system clock, rising edge
//            rst_n_i      - synchronous active-low reset
//            enable_i     - transmitter enable; low blocks new grants
//            req_valid_i  - per-requester word valid
//            req_last_i   - per-requester last-word flag (qualified by valid)
//            req_data_i   - packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//            req_ready_o  - per-requester accept
//            fifo_full_i  - TX FIFO full flag
//            fifo_write_o - TX FIFO write strobe
//            fifo_data_o  - TX FIFO write data (0 when nobody owns the port)
//            grant_o      - one-hot current owner, 0 when none
//            busy_o       - high while a requester owns the port
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_WIDTH    = 31,
   parameter int unsigned MAX_BURST     = 4,
   parameter int unsigned STALL_TIMEOUT = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          enable_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_write_o,
   output logic [DATA_WIDTH-1:0]         fifo_data_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o
);

   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam int unsigned BEAT_W  = $clog2(MAX_BURST) + 1;
   localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT) + 1;
   localparam int          N       = int'(NUM_REQ);

   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     last_q,  last_d;
   logic [BEAT_W-1:0]    beat_q,  beat_d;
   logic [STALL_W-1:0]   stall_q, stall_d;

   logic                 own_valid;
   logic                 own_last;
   logic                 transfer;
   logic                 found;
   logic [IDX_W-1:0]     sel_idx;
   logic [NUM_REQ-1:0]   sel_onehot;
   logic [DATA_WIDTH-1:0] data_mux;

   // Owner qualifiers straight from the one-hot grant.
   assign own_valid = |(req_valid_i & grant_q);
   assign own_last  = |(req_last_i  & grant_q);

   // Ready/write are gated by reset so a reset cycle never writes, even though
   // the registered grant is still set until the edge.
   assign transfer     = (state_q == ST_OWN) && own_valid && !fifo_full_i && rst_n_i;
   assign fifo_write_o = transfer;
   assign req_ready_o  = ((state_q == ST_OWN) && !fifo_full_i && rst_n_i) ? grant_q : '0;
   assign grant_o      = grant_q;
   assign busy_o       = (state_q == ST_OWN);
   assign fifo_data_o  = data_mux;

   // AND-OR data mux: yields zero whenever no grant bit is set.
   always_comb begin
      data_mux = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            data_mux = data_mux | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round-robin pick: each requester gets a rank equal to its distance past
   // the last winner; the valid requester with the smallest rank wins.
   always_comb begin
      int rank;
      int best_rank;
      rank       = 0;
      best_rank  = N;
      sel_idx    = '0;
      sel_onehot = '0;
      for (int i = 0; i < N; i++) begin
         rank = i - int'(last_q) - 1;
         if (rank < 0) begin
            rank = rank + N;
         end
         if (req_valid_i[i] && (rank < best_rank)) begin
            best_rank  = rank;
            sel_idx    = IDX_W'(i);
            sel_onehot = '0;
            sel_onehot[i] = 1'b1;
         end
      end
      found = (best_rank < N);
   end

   always_comb begin
      logic release_now;
      release_now = 1'b0;
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      last_d      = last_q;
      beat_d      = beat_q;
      stall_d     = stall_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_i && found) begin
               state_d = ST_OWN;
               grant_d = sel_onehot;
               owner_d = sel_idx;
               beat_d  = '0;
               stall_d = '0;
            end
         end
         ST_OWN: begin
            if (transfer) begin
               beat_d  = beat_q + BEAT_W'(1);
               stall_d = '0;
               // Last flag and burst limit on the same word fold into one release.
               if (own_last || (beat_q == BEAT_LAST)) begin
                  release_now = 1'b1;
               end
            end else if (!own_valid) begin
               // Only an absent owner counts toward the timeout; a full FIFO does not.
               if (stall_q == STALL_LAST) begin
                  release_now = 1'b1;
               end else begin
                  stall_d = stall_q + STALL_W'(1);
               end
            end
            if (release_now) begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_arbiter
// Purpose  : Directed, table-driven bench for spi_tx_arbiter. Each table row
//            is one clock cycle of inputs with the expected grant and write
//            strobe; ready, busy and FIFO data are derived from those.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 31;

   logic             clk;
   logic             rst_n;
   logic             enable;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_last;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             fifo_full;
   logic             fifo_write;
   logic [DW-1:0]    fifo_data;
   logic [NR-1:0]    grant;
   logic             busy;

   int n_checks;
   int n_fail;

   spi_tx_arbiter #(
      .NUM_REQ      (NR),
      .DATA_WIDTH   (DW),
      .MAX_BURST    (4),
      .STALL_TIMEOUT(8)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .enable_i    (enable),
      .req_valid_i (req_valid),
      .req_last_i  (req_last),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .fifo_full_i (fifo_full),
      .fifo_write_o(fifo_write),
      .fifo_data_o (fifo_data),
      .grant_o     (grant),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst_n;
      logic          en;
      logic [NR-1:0] valid;
      logic [NR-1:0] last;
      logic          full;
      logic [NR-1:0] exp_grant;
      logic          exp_write;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [DW-1:0] data_of(input int i);
      logic [31:0] v;
      v = 32'h1357_0000 + 32'(i) * 32'h0011_1111;
      return v[DW-1:0];
   endfunction

   task automatic add(input logic r, input logic e, input logic [NR-1:0] v,
                      input logic [NR-1:0] l, input logic f,
                      input logic [NR-1:0] g, input logic w);
      vec_t x;
      x.rst_n = r; x.en = e; x.valid = v; x.last = l; x.full = f;
      x.exp_grant = g; x.exp_write = w;
      tbl.push_back(x);
   endtask

   task automatic chk(input string name, input int row,
                      input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic drive_const_data();
      for (int i = 0; i < NR; i++) begin
         req_data[i*DW +: DW] = data_of(i);
      end
   endtask

   initial begin
      logic [DW-1:0]  exp_data;
      logic [NR-1:0]  exp_ready;
      logic [DW-1:0]  w0;
      logic [DW-1:0]  w1;
      int             wr_cnt;

      n_checks = 0;
      n_fail   = 0;

      // ---------------- table construction ----------------
      // Reset held two cycles, then all four requesters valid.
      add(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
      // Round robin 0,1,2,3: four words each, one dead cycle between grants.
      for (int g = 0; g < NR; g++) begin
         repeat (4) add(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'(1 << g), 1'b1);
         add(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
      end
      add(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1);
      // Reset mid-burst: grant still visible, but no write in that cycle.
      add(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0);
      add(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      // Backpressure: 9 full cycles mid-burst, no timeout, burst completes.
      add(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1);
      repeat (9) add(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0);
      repeat (3) add(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1);
      add(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      // Stall timeout: req1 sends one word then goes quiet for 8 cycles.
      add(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1);
      repeat (8) add(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0010, 1'b0);
      add(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0);
      repeat (4) add(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1);
      add(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      // Enable drops after word 2: burst finishes, no new grant until enabled.
      add(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      repeat (2) add(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1);
      repeat (2) add(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1);
      repeat (2) add(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1);
      add(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0);
      add(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      // Last flag on the 4th word: one release, pointer moves to req1 only.
      add(1'b1, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0);
      repeat (3) add(1'b1, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
      add(1'b1, 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1);
      add(1'b1, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 4'b0011, 4'b0010, 1'b0, 4'b0010, 1'b1);
      add(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // ---------------- apply table ----------------
      rst_n = 1'b0; enable = 1'b0; req_valid = '0; req_last = '0;
      fifo_full = 1'b0; req_data = '0;
      drive_const_data();
      @(posedge clk);
      #1;
      for (int r = 0; r < tbl.size(); r++) begin
         rst_n     = tbl[r].rst_n;
         enable    = tbl[r].en;
         req_valid = tbl[r].valid;
         req_last  = tbl[r].last;
         fifo_full = tbl[r].full;
         exp_data  = '0;
         for (int i = 0; i < NR; i++) begin
            if (tbl[r].exp_grant[i]) exp_data = data_of(i);
         end
         exp_ready = (tbl[r].rst_n && !tbl[r].full) ? tbl[r].exp_grant : '0;
         @(negedge clk);
         chk("grant", r, 64'(grant),      64'(tbl[r].exp_grant));
         chk("busy",  r, 64'(busy),       64'(|tbl[r].exp_grant));
         chk("write", r, 64'(fifo_write), 64'(tbl[r].exp_write));
         chk("ready", r, 64'(req_ready),  64'(exp_ready));
         chk("data",  r, 64'(fifo_data),  64'(exp_data));
         @(posedge clk);
         #1;
      end

      // ---------------- last handling: req2, two distinct words ----------------
      // Arbiter is idle with req1 as last winner, so req2 is searched first.
      w0 = 31'h2AAA_0001;
      w1 = 31'h1555_0002;
      wr_cnt = 0;
      enable = 1'b1; fifo_full = 1'b0; rst_n = 1'b1;
      req_valid = 4'b0100; req_last = 4'b0000;
      req_data[2*DW +: DW] = w0;
      @(negedge clk);
      chk("last_idle_grant", 0, 64'(grant), 64'(4'b0000));
      if (fifo_write) wr_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      chk("last_w0_grant", 1, 64'(grant), 64'(4'b0100));
      chk("last_w0_data",  1, 64'(fifo_data), 64'(w0));
      if (fifo_write) wr_cnt++;
      @(posedge clk); #1;
      req_data[2*DW +: DW] = w1;
      req_last = 4'b0100;
      @(negedge clk);
      chk("last_w1_data", 2, 64'(fifo_data), 64'(w1));
      if (fifo_write) wr_cnt++;
      @(posedge clk); #1;
      req_valid = 4'b0000; req_last = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (fifo_write) wr_cnt++;
         if (k == 0) chk("last_grant_drop", 3, 64'(grant), 64'(4'b0000));
         @(posedge clk); #1;
      end
      chk("last_write_count", 4, 64'(wr_cnt), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
